// File: rtl/adc_emulator_pkg.sv
// Shared types and constants for the parallel-ADC emulator slice.
package adc_pkg;

    localparam int unsigned ADC_W  = 8;
    localparam int unsigned CHNL_W = 3;
    localparam int unsigned FC_W   = 16;
    localparam int unsigned NUM_CH = 4;

    localparam logic [ADC_W-1:0] LFSR_TAPS   = 8'hB8;
    localparam logic [ADC_W-1:0] UNUSED_CODE = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        READY,
        READ
    } adc_emu_state_t;

    // Fibonacci step: x^8+x^6+x^5+x^4+1, feedback shifted into bit 0.
    function automatic logic [ADC_W-1:0] lfsr_next(input logic [ADC_W-1:0] s);
        return {s[ADC_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/adc_emulator_if.sv
// ADC parallel bus plus emulator status, seen from initiator (master) and emulator (slave).
interface adc_emulator_if;
    import adc_pkg::*;

    logic [CHNL_W-1:0] chnl;
    logic              n_convst;
    logic              n_cs;
    logic              n_rd;
    logic              n_eoc;
    logic [ADC_W-1:0]  adc_out;
    logic              adc_oe;
    logic              protocol_err;
    logic [FC_W-1:0]   frame_count;

    modport master (
        output chnl, n_convst, n_cs, n_rd,
        input  n_eoc, adc_out, adc_oe, protocol_err, frame_count
    );

    modport slave (
        input  chnl, n_convst, n_cs, n_rd,
        output n_eoc, adc_out, adc_oe, protocol_err, frame_count
    );

endinterface

// File: rtl/adc_emulator_lfsr8_history.sv
// 8-bit LFSR feeding a byte history; channel c taps the sample c*LAG frames old.
module lfsr8_history
    import adc_pkg::*;
#(
    parameter int unsigned      LAG  = 4,
    parameter logic [ADC_W-1:0] SEED = 8'h01
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           step_i,
    output logic [NUM_CH-1:0][ADC_W-1:0]   tap_o
);

    localparam int unsigned DEPTH = 3 * LAG + 1;

    logic [ADC_W-1:0]            lfsr_q;
    logic [DEPTH-1:0][ADC_W-1:0] hist_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
            hist_q <= '0;
        end else if (step_i) begin
            lfsr_q <= lfsr_next(lfsr_q);
            hist_q <= {hist_q[DEPTH-2:0], lfsr_q};
        end
    end

    always_comb begin
        tap_o = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            tap_o[c] = hist_q[c*LAG];
        end
    end

endmodule

// File: rtl/adc_emulator.sv
// Emulates the external 8-bit ADC: start/convert/eoc/read handshake with LFSR-derived data.
module adc_emulator
    import adc_pkg::*;
#(
    parameter int unsigned      CONV_CYCLES = 8,
    parameter int unsigned      LAG         = 4,
    parameter logic [ADC_W-1:0] SEED        = 8'h01
) (
    input  logic          clk,
    input  logic          n_reset,
    adc_emulator_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(CONV_CYCLES);

    adc_emu_state_t state_q, state_d;

    logic              convst_q, convst_prev_q, cs_q, rd_q;
    logic [CHNL_W-1:0] chnl_q;
    logic [CHNL_W-1:0] chnl_lat_q, chnl_lat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADC_W-1:0]  data_q, data_d;
    logic [ADC_W-1:0]  adc_out_q, adc_out_d;
    logic              n_eoc_q, n_eoc_d;
    logic              adc_oe_q, adc_oe_d;
    logic              err_q, err_d;
    logic [FC_W-1:0]   fc_q, fc_d;

    logic                         start, read_act, accept, step, violation;
    logic [NUM_CH-1:0][ADC_W-1:0] tap;
    logic [ADC_W-1:0]             value;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            convst_q      <= 1'b1;
            convst_prev_q <= 1'b1;
            cs_q          <= 1'b1;
            rd_q          <= 1'b1;
            chnl_q        <= '1;
        end else begin
            convst_q      <= bus.n_convst;
            convst_prev_q <= convst_q;
            cs_q          <= bus.n_cs;
            rd_q          <= bus.n_rd;
            chnl_q        <= bus.chnl;
        end
    end

    assign start    = convst_prev_q & ~convst_q;
    assign read_act = ~cs_q & ~rd_q;
    assign accept   = (state_q == IDLE) && start;
    assign step     = accept && (chnl_q == '0);
    // Start outranks read in IDLE, read outranks start in READY; the loser is flagged.
    assign violation = (start && (state_q != IDLE))
                    || (read_act && ((state_q == IDLE) || (state_q == CONVERT)));

    lfsr8_history #(
        .LAG  (LAG),
        .SEED (SEED)
    ) u_hist (
        .clk_i  (clk),
        .rst_ni (n_reset),
        .step_i (step),
        .tap_o  (tap)
    );

    assign value = (chnl_lat_q < CHNL_W'(NUM_CH)) ? tap[chnl_lat_q[1:0]] : UNUSED_CODE;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)          state_d = CONVERT;
            CONVERT: if (cnt_q == '0)    state_d = READY;
            READY:   if (read_act)       state_d = READ;
            READ:    if (!read_act)      state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_comb begin
        chnl_lat_d = chnl_lat_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        adc_out_d  = adc_out_q;
        n_eoc_d    = n_eoc_q;
        adc_oe_d   = adc_oe_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    chnl_lat_d = chnl_q;
                    cnt_d      = CNT_W'(CONV_CYCLES - 1);
                end
            end
            CONVERT: begin
                if (cnt_q == '0) begin
                    data_d  = value;
                    n_eoc_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            READY: begin
                if (read_act) begin
                    n_eoc_d   = 1'b1;
                    adc_oe_d  = 1'b1;
                    adc_out_d = data_q;
                end
            end
            READ: begin
                if (!read_act) adc_oe_d = 1'b0;
            end
            default: ;
        endcase
        err_d = err_q | violation;
        fc_d  = step ? fc_q + FC_W'(1) : fc_q;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            chnl_lat_q <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            adc_out_q  <= '0;
            n_eoc_q    <= 1'b1;
            adc_oe_q   <= 1'b0;
            err_q      <= 1'b0;
            fc_q       <= '0;
        end else begin
            chnl_lat_q <= chnl_lat_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            adc_out_q  <= adc_out_d;
            n_eoc_q    <= n_eoc_d;
            adc_oe_q   <= adc_oe_d;
            err_q      <= err_d;
            fc_q       <= fc_d;
        end
    end

    assign bus.n_eoc        = n_eoc_q;
    assign bus.adc_out      = adc_out_q;
    assign bus.adc_oe       = adc_oe_q;
    assign bus.protocol_err = err_q;
    assign bus.frame_count  = fc_q;

endmodule
